// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   - ctrl_state_e : controller FSM states
//   - pipe_ctrl_t  : bundle of PC / pipeline-register enables and flushes
//   - ctrl_uniform : builds a pipe_ctrl_t with every enable and every flush
//                    set to the same value
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } pipe_ctrl_t;

  function automatic pipe_ctrl_t ctrl_uniform(input logic en, input logic flush);
    pipe_ctrl_t c;
    c.pc_en       = en;
    c.ifid_en     = en;
    c.idex_en     = en;
    c.exmem_en    = en;
    c.memwb_en    = en;
    c.ifid_flush  = flush;
    c.idex_flush  = flush;
    c.memwb_flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard sources coming from the datapath and the sequencing
// controls going back to it.
//   master : datapath side - drives hazard sources, receives controls
//   slave  : controller side - receives hazard sources, drives controls
// Hazard sources: IFID_rs1/rs2, IDEX_MemoryRead, IDEX_rd, EXMEM_MemoryRead,
//   EXMEM_MemoryWrite, mem_ready, branch_taken.
// Controls: pc_en, ifid/idex/exmem/memwb_en, ifid/idex/memwb_flush,
//   mem_error, stall_count[CNT_W].
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] IFID_rs1;
  logic [REG_ADDR_W-1:0] IFID_rs2;
  logic                  IDEX_MemoryRead;
  logic [REG_ADDR_W-1:0] IDEX_rd;
  logic                  EXMEM_MemoryRead;
  logic                  EXMEM_MemoryWrite;
  logic                  mem_ready;
  logic                  branch_taken;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  idex_en;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  memwb_flush;
  logic                  mem_error;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output IFID_rs1, IFID_rs2, IDEX_MemoryRead, IDEX_rd,
           EXMEM_MemoryRead, EXMEM_MemoryWrite, mem_ready, branch_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush, mem_error, stall_count
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IDEX_MemoryRead, IDEX_rd,
           EXMEM_MemoryRead, EXMEM_MemoryWrite, mem_ready, branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush, mem_error, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_hazard_detect
// Combinational load-use detector: the load in EX writes a register that
// the instruction in ID reads. x0 is hard-wired zero, so rd=0 never hazards.
//   idex_mem_read_i : instruction in EX is a load
//   idex_rd_i       : destination register of the instruction in EX
//   ifid_rs1_i/rs2_i: source registers of the instruction in ID
//   load_use_o      : one-bubble stall required
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
  output logic                  load_use_o
);

  logic rd_nonzero;
  logic rs_match;

  assign rd_nonzero = (idex_rd_i != '0);
  assign rs_match   = (idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i);
  assign load_use_o = idex_mem_read_i && rd_nonzero && rs_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Per-cycle advance / hold / bubble sequencing for the PC and the IF/ID,
// ID/EX, EX/MEM and MEM/WB registers of the five-stage core. Also counts
// cycles with the PC held (saturating) and flags a data-memory timeout.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pipeline_hazard_ctrl_if.slave (hazard sources in, controls out)
// Parameters:
//   CNT_W       : stall_count width
//   MEM_TIMEOUT : consecutive memory-wait cycles tolerated before ERROR (1..255)
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal flow; load-use / branch handled with bubbles
// MEM_WAIT | data access outstanding in MEM; upstream frozen, MEM/WB bubbled
// ERROR    | memory timed out; whole pipeline frozen until reset
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_hazard_ctrl_if.slave       bus
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE    = WAIT_CNT_W'(1);
  localparam logic [CNT_W-1:0]      STALL_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      STALL_MAX   = '1;

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_inc;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  mem_error_q, mem_error_d;

  logic                  load_use;
  logic                  mem_busy;
  pipe_ctrl_t            ctrl;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .idex_mem_read_i (bus.IDEX_MemoryRead),
    .idex_rd_i       (bus.IDEX_rd),
    .ifid_rs1_i      (bus.IFID_rs1),
    .ifid_rs2_i      (bus.IFID_rs2),
    .load_use_o      (load_use)
  );

  assign mem_busy = (bus.EXMEM_MemoryRead || bus.EXMEM_MemoryWrite) && !bus.mem_ready;
  assign wait_inc = wait_cnt_q + WAIT_ONE;

  // Next-state and control decode. RUN and MEM_WAIT share the same priority
  // chain: once memory stops being busy, MEM_WAIT behaves exactly like RUN,
  // so a branch held in the frozen EX stage is honoured on the release cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    ctrl        = ctrl_uniform(1'b1, 1'b0);

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          // Freeze everything behind MEM; MEM/WB takes a bubble so WB does
          // not retire the stalled access twice.
          ctrl             = ctrl_uniform(1'b0, 1'b0);
          ctrl.memwb_en    = 1'b1;
          ctrl.memwb_flush = 1'b1;
          wait_cnt_d       = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            state_d     = ERROR;
            mem_error_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (bus.branch_taken) begin
            // Kill the two wrong-path instructions in IF/ID and ID/EX; any
            // load-use seen this cycle belongs to a killed instruction.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end
      end
      ERROR: begin
        ctrl = ctrl_uniform(1'b0, 1'b0);
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (rst) begin
      ctrl = ctrl_uniform(1'b0, 1'b1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.mem_error   = mem_error_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two controller instances share one stimulus stream:
//   dut0 : CNT_W=16, MEM_TIMEOUT=255
//   dut1 : CNT_W=3,  MEM_TIMEOUT=4
// Expected controls are queued when inputs are driven and compared at the
// following falling edge. Control vector order:
//   {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam logic [7:0] C_NRM = 8'b11111_000;
  localparam logic [7:0] C_RST = 8'b00000_111;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_MB  = 8'b00001_001;
  localparam logic [7:0] C_ERR = 8'b00000_000;

  localparam int S_RUN = 0;
  localparam int S_MW  = 1;
  localparam int S_ERR = 2;

  typedef struct {
    string      tag;
    int         dut;
    logic [7:0] ctrl;
    int         stall;
    logic       err;
    int         st;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, idex_rd;
  logic       idex_mr, ex_mr, ex_mw, mem_ready, br;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  if1 ();

  assign if0.IFID_rs1          = rs1;
  assign if0.IFID_rs2          = rs2;
  assign if0.IDEX_MemoryRead   = idex_mr;
  assign if0.IDEX_rd           = idex_rd;
  assign if0.EXMEM_MemoryRead  = ex_mr;
  assign if0.EXMEM_MemoryWrite = ex_mw;
  assign if0.mem_ready         = mem_ready;
  assign if0.branch_taken      = br;

  assign if1.IFID_rs1          = rs1;
  assign if1.IFID_rs2          = rs2;
  assign if1.IDEX_MemoryRead   = idex_mr;
  assign if1.IDEX_rd           = idex_rd;
  assign if1.EXMEM_MemoryRead  = ex_mr;
  assign if1.EXMEM_MemoryWrite = ex_mw;
  assign if1.mem_ready         = mem_ready;
  assign if1.branch_taken      = br;

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  task automatic push_exp(input string tag, input int d, input logic [7:0] c,
                          input int stall, input logic err, input int st);
    exp_t e;
    e.tag   = tag;
    e.dut   = d;
    e.ctrl  = c;
    e.stall = stall;
    e.err   = err;
    e.st    = st;
    sb.push_back(e);
  endtask

  task automatic push_both(input string tag, input logic [7:0] c,
                           input int stall, input logic err, input int st);
    push_exp(tag, 0, c, stall, err, st);
    push_exp(tag, 1, c, stall, err, st);
  endtask

  // Compare everything queued for this cycle, then move to just after the
  // next rising edge so the caller can drive the following step.
  task automatic cyc();
    exp_t        e;
    logic [7:0]  oc;
    logic [31:0] os;
    logic        oe;
    logic [31:0] ost;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        oc  = {if0.pc_en, if0.ifid_en, if0.idex_en, if0.exmem_en, if0.memwb_en,
               if0.ifid_flush, if0.idex_flush, if0.memwb_flush};
        os  = 32'(if0.stall_count);
        oe  = if0.mem_error;
        ost = 32'(dut0.state_q);
      end else begin
        oc  = {if1.pc_en, if1.ifid_en, if1.idex_en, if1.exmem_en, if1.memwb_en,
               if1.ifid_flush, if1.idex_flush, if1.memwb_flush};
        os  = 32'(if1.stall_count);
        oe  = if1.mem_error;
        ost = 32'(dut1.state_q);
      end
      checks++;
      assert (oc === e.ctrl) else begin
        errors++;
        $error("FAIL %s ctrl dut%0d: observed %b expected %b", e.tag, e.dut, oc, e.ctrl);
      end
      checks++;
      assert (os === 32'(e.stall)) else begin
        errors++;
        $error("FAIL %s stall_count dut%0d: observed %0d expected %0d", e.tag, e.dut, os, e.stall);
      end
      checks++;
      assert (oe === e.err) else begin
        errors++;
        $error("FAIL %s mem_error dut%0d: observed %b expected %b", e.tag, e.dut, oe, e.err);
      end
      if (e.st >= 0) begin
        checks++;
        assert (ost === 32'(e.st)) else begin
          errors++;
          $error("FAIL %s state dut%0d: observed %0d expected %0d", e.tag, e.dut, ost, e.st);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; idex_rd = '0;
    idex_mr = 1'b0; ex_mr = 1'b0; ex_mw = 1'b0; mem_ready = 1'b0; br = 1'b0;
    @(posedge clk);
    #1;

    // reset held two cycles, then release
    push_both("rst_a", C_RST, 0, 1'b0, S_RUN); cyc();
    push_both("rst_b", C_RST, 0, 1'b0, S_RUN); cyc();
    rst = 1'b0;
    push_both("run_idle", C_NRM, 0, 1'b0, S_RUN); cyc();

    // load-use on rs2, then rd=x0, then rs1 match, then non-load match
    idex_mr = 1'b1; idex_rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
    push_both("lu_rs2", C_LU, 0, 1'b0, S_RUN); cyc();
    idex_mr = 1'b0;
    push_both("lu_done", C_NRM, 1, 1'b0, S_RUN); cyc();
    idex_mr = 1'b1; idex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    push_both("rd_x0", C_NRM, 1, 1'b0, S_RUN); cyc();
    idex_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd2;
    push_both("lu_rs1", C_LU, 1, 1'b0, S_RUN); cyc();
    idex_mr = 1'b0;
    push_both("no_load", C_NRM, 2, 1'b0, S_RUN); cyc();

    // branch wins over load-use in the same cycle
    idex_mr = 1'b1; idex_rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; br = 1'b1;
    push_both("br_lu", C_BR, 2, 1'b0, S_RUN); cyc();
    idex_mr = 1'b0; br = 1'b0;
    push_both("after_br", C_NRM, 2, 1'b0, S_RUN); cyc();

    // store completing in the same cycle causes no wait
    ex_mw = 1'b1; mem_ready = 1'b1;
    push_both("st_ready", C_NRM, 2, 1'b0, S_RUN); cyc();
    ex_mw = 1'b0; mem_ready = 1'b0;

    // memory wait: 3 frozen cycles, branch held and taken on release
    rst = 1'b1;
    push_both("rst_c", C_RST, 2, 1'b0, S_RUN); cyc();
    rst = 1'b0; ex_mr = 1'b1; mem_ready = 1'b0; br = 1'b1;
    push_both("mw1", C_MB, 0, 1'b0, S_RUN); cyc();
    push_both("mw2", C_MB, 1, 1'b0, S_MW); cyc();
    push_both("mw3", C_MB, 2, 1'b0, S_MW); cyc();
    mem_ready = 1'b1;
    push_both("mw_rel", C_BR, 3, 1'b0, S_MW); cyc();
    ex_mr = 1'b0; mem_ready = 1'b0; br = 1'b0;
    push_both("mw_after", C_NRM, 3, 1'b0, S_RUN); cyc();

    // reset asserted while in MEM_WAIT
    ex_mr = 1'b1;
    push_both("mw_pre", C_MB, 3, 1'b0, S_RUN); cyc();
    rst = 1'b1;
    push_both("rst_mw", C_RST, 4, 1'b0, S_MW); cyc();
    rst = 1'b0; ex_mr = 1'b0;
    push_both("rst_mw_run", C_NRM, 0, 1'b0, S_RUN); cyc();

    // timeout on dut1 (MEM_TIMEOUT=4), sticky error, cleared by reset
    ex_mr = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp("to_wait", 1, C_MB, i, 1'b0, (i == 0) ? S_RUN : S_MW); cyc();
    end
    push_exp("to_err", 1, C_ERR, 4, 1'b1, S_ERR); cyc();
    ex_mr = 1'b0; mem_ready = 1'b1;
    push_exp("err_sticky", 1, C_ERR, 5, 1'b1, S_ERR); cyc();
    rst = 1'b1;
    push_exp("err_rst", 1, C_RST, 6, 1'b1, S_ERR); cyc();
    rst = 1'b0; mem_ready = 1'b0;
    push_both("err_clr", C_NRM, 0, 1'b0, S_RUN); cyc();

    // saturation on dut1 (CNT_W=3) with 9 load-use stalls; dut0 keeps counting
    idex_mr = 1'b1; idex_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd0;
    for (int i = 0; i < 9; i++) begin
      push_exp("sat", 1, C_LU, (i < 7) ? i : 7, 1'b0, S_RUN);
      push_exp("nosat", 0, C_LU, i, 1'b0, S_RUN);
      cyc();
    end
    idex_mr = 1'b0;
    push_exp("sat_hold", 1, C_NRM, 7, 1'b0, S_RUN);
    push_exp("nosat_hold", 0, C_NRM, 9, 1'b0, S_RUN);
    cyc();
    idex_mr = 1'b1;
    push_exp("sat_again", 1, C_LU, 7, 1'b0, S_RUN); cyc();
    idex_mr = 1'b0;
    push_exp("sat_final", 1, C_NRM, 7, 1'b0, S_RUN); cyc();

    // dut0: 254 wait cycles then release stays clear of the 255 timeout
    rst = 1'b1; cyc();
    rst = 1'b0; ex_mr = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 254; i++) begin
      push_exp("w254", 0, C_MB, i, 1'b0, (i == 0) ? S_RUN : S_MW); cyc();
    end
    mem_ready = 1'b1;
    push_exp("w254_rel", 0, C_NRM, 254, 1'b0, S_MW); cyc();
    ex_mr = 1'b0; mem_ready = 1'b0;
    push_exp("w254_run", 0, C_NRM, 254, 1'b0, S_RUN); cyc();

    // dut0: 255 wait cycles reach the timeout
    rst = 1'b1; cyc();
    rst = 1'b0; ex_mr = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 255; i++) begin
      push_exp("w255", 0, C_MB, i, 1'b0, (i == 0) ? S_RUN : S_MW); cyc();
    end
    push_exp("to255", 0, C_ERR, 255, 1'b1, S_ERR); cyc();
    ex_mr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
